// File: rtl/button_debouncer.sv
// Per-channel push-button conditioner: synchroniser, bounce filter, debounced level
// and single-cycle press/release pulses.
module button_debouncer #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  output logic [NUM_BUTTONS-1:0] buttons_o,
  output logic [NUM_BUTTONS-1:0] pressed_o,
  output logic [NUM_BUTTONS-1:0] released_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debouncer: SYNC_STAGES must be >= 2");
  end

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          count_reg;
    logic                   level_reg;
    logic                   pressed_reg;
    logic                   released_reg;
    logic                   sync;

    assign sync = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], buttons_i[gi]};
      end
    end

    // The counter only runs while the synchronised pin disagrees with the
    // accepted level; any agreeing cycle throws away the partial count.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        count_reg    <= '0;
        level_reg    <= 1'b0;
        pressed_reg  <= 1'b0;
        released_reg <= 1'b0;
      end else begin
        pressed_reg  <= 1'b0;
        released_reg <= 1'b0;
        if (sync == level_reg) begin
          count_reg <= '0;
        end else if (count_reg == LAST_COUNT) begin
          count_reg    <= '0;
          level_reg    <= sync;
          pressed_reg  <= sync;
          released_reg <= ~sync;
        end else begin
          count_reg <= count_reg + ONE;
        end
      end
    end

    assign buttons_o[gi]  = level_reg;
    assign pressed_o[gi]  = pressed_reg;
    assign released_o[gi] = released_reg;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with 4 channels, 8-cycle filter, 2-stage sync.
module tb_button_debouncer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] buttons_i = 4'b0000;
  logic [3:0] buttons_o;
  logic [3:0] pressed_o;
  logic [3:0] released_o;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  button_debouncer #(
    .NUM_BUTTONS    (4),
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .buttons_i (buttons_i),
    .buttons_o (buttons_o),
    .pressed_o (pressed_o),
    .released_o(released_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] pr;
    logic [3:0] rl;
  } vec_t;

  vec_t tbl [25];

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d: got %b, expected %b", tag, cyc, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] el, input logic [3:0] ep,
                           input logic [3:0] er);
    check({tag, ".level"}, buttons_o, el);
    check({tag, ".pressed"}, pressed_o, ep);
    check({tag, ".released"}, released_o, er);
  endtask

  // Drive one input value, advance one edge, compare all outputs after that edge.
  task automatic step(input string tag, input logic [3:0] b, input logic [3:0] el,
                      input logic [3:0] ep, input logic [3:0] er);
    buttons_i = b;
    @(posedge clk_i);
    #1;
    cyc++;
    $display("[%0d] %s in=%b lvl=%b pr=%b rl=%b", cyc, tag, b, buttons_o, pressed_o, released_o);
    check_all(tag, el, ep, er);
  endtask

  // Hold a value from a settled state: no change for 9 edges, accept on edge 10, pulse gone on 11.
  task automatic settle(input string tag, input logic [3:0] b, input logic [3:0] old_lvl,
                        input logic [3:0] new_lvl, input logic [3:0] ep, input logic [3:0] er);
    for (int k = 1; k <= 9; k++) step(tag, b, old_lvl, 4'b0000, 4'b0000);
    step({tag, ".accept"}, b, new_lvl, ep, er);
    step({tag, ".after"}, b, new_lvl, 4'b0000, 4'b0000);
  endtask

  initial begin
    logic [5:0] bounce;

    // Table: press on ch0, then a 7-cycle glitch on ch1 that must be rejected.
    for (int i = 0; i < 9; i++) tbl[i] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[10] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 12; i < 19; i++) tbl[i] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 19; i < 25; i++) tbl[i] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};

    // Reset held with inputs idle.
    for (int k = 0; k < 3; k++) step("reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst_i = 1'b0;
    for (int k = 0; k < 20; k++) step("post_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < 25; i++) step($sformatf("table[%0d]", i), tbl[i].btn, tbl[i].lvl,
                                      tbl[i].pr, tbl[i].rl);

    // Bounce train on ch2 (ch0 still held): one press 10 edges after the final rise.
    bounce = 6'b101101;
    for (int k = 5; k >= 0; k--) step("bounce", {1'b0, bounce[k], 2'b01}, 4'b0001, 4'b0000, 4'b0000);
    for (int k = 2; k <= 9; k++) step("bounce_wait", 4'b0101, 4'b0001, 4'b0000, 4'b0000);
    step("bounce_accept", 4'b0101, 4'b0101, 4'b0100, 4'b0000);
    for (int k = 0; k < 3; k++) step("bounce_hold", 4'b0101, 4'b0101, 4'b0000, 4'b0000);
    settle("ch2_release", 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0100);

    // Clear ch0, then all four channels at once in both directions.
    settle("ch0_release", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    settle("all_press", 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    settle("all_release", 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111);

    // Reset mid-count on ch3: after 7 edges the count is 5.
    for (int k = 0; k < 7; k++) step("ch3_count", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    rst_i = 1'b1;
    #1;
    check_all("async_reset", 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) step("ch3_in_reset", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    rst_i = 1'b0;
    settle("ch3_after_reset", 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    for (int k = 0; k < 5; k++) step("ch3_hold", 4'b1000, 4'b1000, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
